// File: rtl/fetch_stage_pkg.sv
// Shared fetch constants, IF/ID payload type and small helpers.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'h0000_0004;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{pc: 32'h0, pc_plus4: PC_STEP, instr: NOP_INSTR, valid: 1'b0};

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble (PC fields held), stall holds everything.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        valid
);

  if_id_t q;

  // stall and flush are level controls sampled on every edge; flush wins over stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= IF_ID_RESET;
    end else if (flush) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (!stall) begin
      q <= '{pc: pc_in, pc_plus4: pc_in + PC_STEP, instr: instr_in, valid: 1'b1};
    end
  end

  assign pc       = q.pc;
  assign pc_plus4 = q.pc_plus4;
  assign instr    = q.instr;
  assign valid    = q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_if,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        redirect_misaligned;

  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // A redirect beats stall; misaligned targets are truncated to a word boundary.
  always_comb begin
    pc_next = pc_q + PC_STEP;
    if (redirect_valid) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_next = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      pc_q         <= pc_next;
      misalign_err <= redirect_misaligned;
    end
  end

  assign pc_out = pc_q;

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .pc_in    (pc_q),
    .instr_in (instr_if),
    .pc       (if_id_pc),
    .pc_plus4 (if_id_pc_plus4),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !flush) stall_cnt <= sat_inc(stall_cnt);
      if (flush)           flush_cnt <= sat_inc(flush_cnt);
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out;
  logic [31:0] instr_if;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  // second instance exercising a reset PC at the top of the address space
  logic        rst_w = 1'b1;
  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = 32'h0;
  logic [31:0] pc_w;
  logic [31:0] instr_w;
  logic [31:0] if_id_pc_w;
  logic [31:0] if_id_pc_plus4_w;
  logic [31:0] if_id_instr_w;
  logic        if_id_valid_w;
  logic        misalign_err_w;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_w;
  logic [31:0] flush_cnt_w;
`endif

  logic [31:0] imem [256];
  assign instr_if = imem[pc_out[9:2]];
  assign instr_w  = imem[pc_w[9:2]];

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model of the architecturally visible state
  logic [31:0] m_pc, m_ifpc, m_ifp4, m_instr, m_scnt, m_fcnt;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .instr_if(instr_if),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .misalign_err(misalign_err)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .pc_out(pc_w), .instr_if(instr_w),
    .stall(zero_bit), .flush(zero_bit), .redirect_valid(zero_bit), .redirect_pc(zero_word),
    .if_id_pc(if_id_pc_w), .if_id_pc_plus4(if_id_pc_plus4_w), .if_id_instr(if_id_instr_w),
    .if_id_valid(if_id_valid_w), .misalign_err(misalign_err_w)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt_w), .flush_cnt(flush_cnt_w)
`endif
  );

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifp4 = 32'h4; m_instr = NOP;
    m_valid = 1'b0; m_mis = 1'b0; m_scnt = 32'h0; m_fcnt = 32'h0;
  endtask

  // One clock: apply inputs after the falling edge, advance the model at the rising
  // edge, and return at the next falling edge where outputs are sampled.
  task automatic cycle(input logic s, input logic f, input logic rv, input logic [31:0] rpc);
    logic [31:0] word;
    stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    word = imem[m_pc[9:2]];
    if (f) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (!s) begin
      m_ifpc = m_pc; m_ifp4 = m_pc + 32'd4; m_instr = word; m_valid = 1'b1;
    end
    m_mis = rv && (rpc % 4 != 0);
    if (rv) m_pc = rpc - (rpc % 4);
    else if (!s) m_pc = m_pc + 32'd4;
    if (s && !f && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    if (f && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc_out, 32'h0); end
    n_checks++; if (if_id_instr !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h want %h", if_id_instr, NOP); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_id_valid); end
    n_checks++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_ifpc: got %h want 0", if_id_pc); end
    n_checks++; if (if_id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL rst_ifp4: got %h want 4", if_id_pc_plus4); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b want 0", misalign_err); end
    release_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (if_id_instr !== 32'h0010_0513) begin n_fail++; $display("FAIL rel_instr: got %h want %h", if_id_instr, 32'h0010_0513); end
    n_checks++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL rel_ifpc: got %h want 0", if_id_pc); end
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid: got %b want 1", if_id_valid); end
    n_checks++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL rel_pc: got %h want 4", pc_out); end
  endtask

  task automatic test_stall();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 8", i, pc_out); end
      n_checks++; if (if_id_pc !== 32'h4) begin n_fail++; $display("FAIL stall_ifpc[%0d]: got %h want 4", i, if_id_pc); end
      n_checks++; if (if_id_instr !== imem[1]) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", i, if_id_instr, imem[1]); end
      n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, if_id_valid); end
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (pc_out !== 32'hC) begin n_fail++; $display("FAIL unstall_pc: got %h want c", pc_out); end
    n_checks++; if (if_id_pc !== 32'h8) begin n_fail++; $display("FAIL unstall_ifpc: got %h want 8", if_id_pc); end
  endtask

  task automatic test_redirect_flush();
    cycle(1'b0, 1'b1, 1'b1, 32'h40);
    n_checks++; if (pc_out !== 32'h40) begin n_fail++; $display("FAIL rf_pc: got %h want 40", pc_out); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rf_valid: got %b want 0", if_id_valid); end
    n_checks++; if (if_id_instr !== NOP) begin n_fail++; $display("FAIL rf_instr: got %h want 13", if_id_instr); end
    n_checks++; if (if_id_pc !== 32'h8) begin n_fail++; $display("FAIL rf_ifpc_hold: got %h want 8", if_id_pc); end
    n_checks++; if (if_id_pc_plus4 !== 32'hC) begin n_fail++; $display("FAIL rf_ifp4_hold: got %h want c", if_id_pc_plus4); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (if_id_pc !== 32'h40) begin n_fail++; $display("FAIL rf_target_pc: got %h want 40", if_id_pc); end
    n_checks++; if (if_id_instr !== imem[16]) begin n_fail++; $display("FAIL rf_target_instr: got %h want %h", if_id_instr, imem[16]); end
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL rf_target_valid: got %b want 1", if_id_valid); end
    n_checks++; if (pc_out !== 32'h44) begin n_fail++; $display("FAIL rf_next_pc: got %h want 44", pc_out); end
  endtask

  task automatic test_misalign();
    cycle(1'b0, 1'b0, 1'b1, 32'h42);
    n_checks++; if (pc_out !== 32'h40) begin n_fail++; $display("FAIL mis_pc: got %h want 40", pc_out); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", misalign_err); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", misalign_err); end
    n_checks++; if (pc_out !== 32'h44) begin n_fail++; $display("FAIL mis_next_pc: got %h want 44", pc_out); end
    cycle(1'b1, 1'b0, 1'b1, 32'h80);
    n_checks++; if (pc_out !== 32'h80) begin n_fail++; $display("FAIL redir_over_stall: got %h want 80", pc_out); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL aligned_no_mis: got %b want 0", misalign_err); end
  endtask

  task automatic test_back_to_back();
    logic s, f, rv;
    logic [31:0] rpc;
    for (int i = 0; i < 300; i++) begin
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 6) == 0);
      rv  = ($urandom_range(0, 6) == 0);
      rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom();
      cycle(s, f, rv, rpc);
      n_checks++; if (pc_out !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc_out, m_pc); end
      n_checks++; if (if_id_pc !== m_ifpc) begin n_fail++; $display("FAIL rnd_ifpc[%0d]: got %h want %h", i, if_id_pc, m_ifpc); end
      n_checks++; if (if_id_pc_plus4 !== m_ifp4) begin n_fail++; $display("FAIL rnd_ifp4[%0d]: got %h want %h", i, if_id_pc_plus4, m_ifp4); end
      n_checks++; if (if_id_instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, if_id_instr, m_instr); end
      n_checks++; if (if_id_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, if_id_valid, m_valid); end
      n_checks++; if (misalign_err !== m_mis) begin n_fail++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, misalign_err, m_mis); end
`ifdef FETCH_PERF_CNT_EN
      n_checks++; if (stall_cnt !== m_scnt) begin n_fail++; $display("FAIL rnd_scnt[%0d]: got %0d want %0d", i, stall_cnt, m_scnt); end
      n_checks++; if (flush_cnt !== m_fcnt) begin n_fail++; $display("FAIL rnd_fcnt[%0d]: got %0d want %0d", i, flush_cnt, m_fcnt); end
`endif
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst = 1'b1;
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (stall_cnt !== 32'h0) begin n_fail++; $display("FAIL cnt_rst_stall: got %0d want 0", stall_cnt); end
    n_checks++; if (flush_cnt !== 32'h0) begin n_fail++; $display("FAIL cnt_rst_flush: got %0d want 0", flush_cnt); end
    release_reset();
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL cnt_stall: got %0d want 5", stall_cnt); end
    n_checks++; if (flush_cnt !== 32'd2) begin n_fail++; $display("FAIL cnt_flush: got %0d want 2", flush_cnt); end
  endtask
`endif

  task automatic test_reset_mid_stall();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL sf_bubble_valid: got %b want 0", if_id_valid); end
    n_checks++; if (if_id_instr !== NOP) begin n_fail++; $display("FAIL sf_bubble_instr: got %h want 13", if_id_instr); end
    n_checks++; if (pc_out !== m_pc) begin n_fail++; $display("FAIL sf_pc_hold: got %h want %h", pc_out, m_pc); end
    stall = 1'b1; flush = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL async_pc: got %h want 0", pc_out); end
    n_checks++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL async_ifpc: got %h want 0", if_id_pc); end
    n_checks++; if (if_id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL async_ifp4: got %h want 4", if_id_pc_plus4); end
    n_checks++; if (if_id_instr !== NOP) begin n_fail++; $display("FAIL async_instr: got %h want 13", if_id_instr); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", if_id_valid); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL async_mis: got %b want 0", misalign_err); end
    @(posedge clk);
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    release_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL post_rst_pc: got %h want 4", pc_out); end
    n_checks++; if (if_id_instr !== 32'h0010_0513) begin n_fail++; $display("FAIL post_rst_instr: got %h want %h", if_id_instr, 32'h0010_0513); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    n_checks++; if (pc_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_rst_pc: got %h want fffffffc", pc_w); end
    rst_w = 1'b0;
    @(negedge clk);
    n_checks++; if (if_id_pc_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_ifpc: got %h want fffffffc", if_id_pc_w); end
    n_checks++; if (if_id_pc_plus4_w !== 32'h0) begin n_fail++; $display("FAIL wrap_ifp4: got %h want 0", if_id_pc_plus4_w); end
    n_checks++; if (pc_w !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", pc_w); end
    n_checks++; if (if_id_instr_w !== imem[255]) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", if_id_instr_w, imem[255]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom();
    imem[0] = 32'h0010_0513;
    model_reset();
    test_reset();
    test_stall();
    test_redirect_flush();
    test_misalign();
    test_back_to_back();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_reset_mid_stall();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
